// File: rtl/stream_width_converter.sv
// AXI-Stream data width converter: packs narrow beats into wide words or splits wide
// words into narrow beats, LSB-first, with a registered output stage.
module stream_width_converter #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 48
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [IN_WIDTH-1:0]  in0_V_TDATA,
  input  logic                 in0_V_TVALID,
  output logic                 in0_V_TREADY,
  output logic [OUT_WIDTH-1:0] out_V_TDATA,
  output logic                 out_V_TVALID,
  input  logic                 out_V_TREADY
);

  localparam int unsigned K    = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH / OUT_WIDTH
                                                        : OUT_WIDTH / IN_WIDTH;
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

  if (((IN_WIDTH % OUT_WIDTH) != 0) && ((OUT_WIDTH % IN_WIDTH) != 0)) begin : g_bad_width
    $error("stream_width_converter: widths must be integer multiples of each other");
  end

  if ((K > 1) && (OUT_WIDTH == K * IN_WIDTH)) begin : g_pack
    logic [(K-1)*IN_WIDTH-1:0] r_buf;
    logic [OUT_WIDTH-1:0]      r_data;
    logic                      r_valid;
    logic [CntW-1:0]           r_cnt;
    logic                      w_last;
    logic                      w_in_fire;
    logic                      w_out_fire;

    assign w_last       = (r_cnt == CntW'(K - 1));
    // Only the final beat of a word needs room in the output register.
    assign in0_V_TREADY = !ap_rst && (!w_last || !r_valid || out_V_TREADY);
    assign w_in_fire    = in0_V_TVALID && in0_V_TREADY;
    assign w_out_fire   = r_valid && out_V_TREADY;

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        r_buf   <= '0;
        r_data  <= '0;
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else begin
        if (w_out_fire) r_valid <= 1'b0;
        if (w_in_fire) begin
          if (w_last) begin
            r_data  <= {in0_V_TDATA, r_buf};
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end else begin
            for (int i = 0; i < int'(K) - 1; i++) begin
              if (r_cnt == CntW'(i)) r_buf[i*IN_WIDTH +: IN_WIDTH] <= in0_V_TDATA;
            end
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign out_V_TDATA  = r_data;
    assign out_V_TVALID = r_valid;
  end else if ((K > 1) && (IN_WIDTH == K * OUT_WIDTH)) begin : g_split
    logic [IN_WIDTH-1:0] r_shift;
    logic                r_valid;
    logic [CntW-1:0]     r_cnt;
    logic                w_last;
    logic                w_in_fire;
    logic                w_out_fire;

    assign w_last       = (r_cnt == CntW'(K - 1));
    assign in0_V_TREADY = !ap_rst && (!r_valid || (w_last && out_V_TREADY));
    assign w_in_fire    = in0_V_TVALID && in0_V_TREADY;
    assign w_out_fire   = r_valid && out_V_TREADY;

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        r_shift <= '0;
        r_valid <= 1'b0;
        r_cnt   <= '0;
      end else if (w_in_fire) begin
        // Also covers the last-slice accept that overlaps a new word: no bubble.
        r_shift <= in0_V_TDATA;
        r_valid <= 1'b1;
        r_cnt   <= '0;
      end else if (w_out_fire) begin
        if (w_last) begin
          r_valid <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_shift <= r_shift >> OUT_WIDTH;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end

    assign out_V_TDATA  = r_shift[OUT_WIDTH-1:0];
    assign out_V_TVALID = r_valid;
  end else begin : g_pass
    logic [OUT_WIDTH-1:0] r_data;
    logic                 r_valid;
    logic                 w_in_fire;
    logic                 w_out_fire;

    assign in0_V_TREADY = !ap_rst && (!r_valid || out_V_TREADY);
    assign w_in_fire    = in0_V_TVALID && in0_V_TREADY;
    assign w_out_fire   = r_valid && out_V_TREADY;

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_data  <= OUT_WIDTH'(in0_V_TDATA);
        r_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_valid <= 1'b0;
      end
    end

    assign out_V_TDATA  = r_data;
    assign out_V_TVALID = r_valid;
  end

endmodule

// File: tb/tb_stream_width_converter.sv
// Bench for stream_width_converter: pack 16->48, split 48->16 and pass 16->16 instances,
// directed steps plus randomized traffic scored against queue-based reference models.
module tb_stream_width_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic ap_rst;

  logic [15:0] pk_in_data;  logic pk_in_valid, pk_in_ready;
  logic [47:0] pk_out_data; logic pk_out_valid, pk_out_ready;
  logic [47:0] sp_in_data;  logic sp_in_valid, sp_in_ready;
  logic [15:0] sp_out_data; logic sp_out_valid, sp_out_ready;
  logic [15:0] ps_in_data;  logic ps_in_valid, ps_in_ready;
  logic [15:0] ps_out_data; logic ps_out_valid, ps_out_ready;

  stream_width_converter #(.IN_WIDTH(16), .OUT_WIDTH(48)) u_pack (
    .ap_clk(clk), .ap_rst(ap_rst),
    .in0_V_TDATA(pk_in_data), .in0_V_TVALID(pk_in_valid), .in0_V_TREADY(pk_in_ready),
    .out_V_TDATA(pk_out_data), .out_V_TVALID(pk_out_valid), .out_V_TREADY(pk_out_ready));

  stream_width_converter #(.IN_WIDTH(48), .OUT_WIDTH(16)) u_split (
    .ap_clk(clk), .ap_rst(ap_rst),
    .in0_V_TDATA(sp_in_data), .in0_V_TVALID(sp_in_valid), .in0_V_TREADY(sp_in_ready),
    .out_V_TDATA(sp_out_data), .out_V_TVALID(sp_out_valid), .out_V_TREADY(sp_out_ready));

  stream_width_converter #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_pass (
    .ap_clk(clk), .ap_rst(ap_rst),
    .in0_V_TDATA(ps_in_data), .in0_V_TVALID(ps_in_valid), .in0_V_TREADY(ps_in_ready),
    .out_V_TDATA(ps_out_data), .out_V_TVALID(ps_out_valid), .out_V_TREADY(ps_out_ready));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference models: accepted beats become expected output words in order.
  logic [15:0] pk_part[$];
  logic [47:0] pk_exp[$];
  logic [15:0] sp_exp[$];
  logic [15:0] ps_exp[$];
  int pk_out_cnt = 0, sp_out_cnt = 0, ps_out_cnt = 0;
  logic pk_stall = 1'b0, sp_stall = 1'b0, ps_stall = 1'b0;
  logic [47:0] pk_hold;
  logic [15:0] sp_hold, ps_hold;
  logic [47:0] pk_word;

  always @(negedge clk) begin
    if (pk_stall) begin
      chk("pk_hold_valid", 64'(pk_out_valid), 64'(1));
      chk("pk_hold_data", 64'(pk_out_data), 64'(pk_hold));
    end
    if (sp_stall) begin
      chk("sp_hold_valid", 64'(sp_out_valid), 64'(1));
      chk("sp_hold_data", 64'(sp_out_data), 64'(sp_hold));
    end
    if (ps_stall) begin
      chk("ps_hold_valid", 64'(ps_out_valid), 64'(1));
      chk("ps_hold_data", 64'(ps_out_data), 64'(ps_hold));
    end
    pk_stall = pk_out_valid && !pk_out_ready && !ap_rst; pk_hold = pk_out_data;
    sp_stall = sp_out_valid && !sp_out_ready && !ap_rst; sp_hold = sp_out_data;
    ps_stall = ps_out_valid && !ps_out_ready && !ap_rst; ps_hold = ps_out_data;

    if (pk_out_valid && pk_out_ready) begin
      pk_out_cnt++;
      chk("pk_expected_word", 64'(pk_exp.size() > 0), 64'(1));
      if (pk_exp.size() > 0) chk("pk_word", 64'(pk_out_data), 64'(pk_exp.pop_front()));
    end
    if (sp_out_valid && sp_out_ready) begin
      sp_out_cnt++;
      chk("sp_expected_slice", 64'(sp_exp.size() > 0), 64'(1));
      if (sp_exp.size() > 0) chk("sp_slice", 64'(sp_out_data), 64'(sp_exp.pop_front()));
    end
    if (ps_out_valid && ps_out_ready) begin
      ps_out_cnt++;
      chk("ps_expected_word", 64'(ps_exp.size() > 0), 64'(1));
      if (ps_exp.size() > 0) chk("ps_word", 64'(ps_out_data), 64'(ps_exp.pop_front()));
    end

    if (pk_in_valid && pk_in_ready) begin
      pk_part.push_back(pk_in_data);
      if (pk_part.size() == 3) begin
        pk_word = '0;
        for (int i = 0; i < 3; i++) pk_word[16*i +: 16] = pk_part[i];
        pk_exp.push_back(pk_word);
        pk_part.delete();
      end
    end
    if (sp_in_valid && sp_in_ready)
      for (int i = 0; i < 3; i++) sp_exp.push_back(sp_in_data[16*i +: 16]);
    if (ps_in_valid && ps_in_ready) ps_exp.push_back(ps_in_data);

    if (ap_rst) begin
      chk("pk_rst_in_ready", 64'(pk_in_ready), 64'(0));
      chk("sp_rst_in_ready", 64'(sp_in_ready), 64'(0));
      chk("ps_rst_in_ready", 64'(ps_in_ready), 64'(0));
      pk_part.delete(); pk_exp.delete(); sp_exp.delete(); ps_exp.delete();
    end
  end

  // Senders: called and returning at posedge+1; return just after the accepting edge.
  task automatic pk_send(input logic [15:0] d);
    int t = 0;
    logic acc = 1'b0;
    pk_in_data = d; pk_in_valid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk); acc = pk_in_ready; @(posedge clk); #1; t++;
    end
    chk("pk_send_accepted", 64'(acc), 64'(1));
    pk_in_valid = 1'b0;
  endtask

  task automatic sp_send(input logic [47:0] d);
    int t = 0;
    logic acc = 1'b0;
    sp_in_data = d; sp_in_valid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk); acc = sp_in_ready; @(posedge clk); #1; t++;
    end
    chk("sp_send_accepted", 64'(acc), 64'(1));
    sp_in_valid = 1'b0;
  endtask

  task automatic ps_send(input logic [15:0] d);
    int t = 0;
    logic acc = 1'b0;
    ps_in_data = d; ps_in_valid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk); acc = ps_in_ready; @(posedge clk); #1; t++;
    end
    chk("ps_send_accepted", 64'(acc), 64'(1));
    ps_in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc_cnt, base, w;
  logic [15:0] t2[6];
  logic [15:0] exp3[6];
  logic sp_done, ps_done;
  logic [47:0] r48;

  initial begin
    ap_rst = 1'b1;
    pk_in_valid = 1'b0; sp_in_valid = 1'b0; ps_in_valid = 1'b0;
    pk_in_data = '0; sp_in_data = '0; ps_in_data = '0;
    pk_out_ready = 1'b0; sp_out_ready = 1'b0; ps_out_ready = 1'b0;
    sp_done = 1'b0; ps_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pk_valid", 64'(pk_out_valid), 64'(0));
    chk("rst_pk_data", 64'(pk_out_data), 64'(0));
    chk("rst_sp_valid", 64'(sp_out_valid), 64'(0));
    chk("rst_sp_data", 64'(sp_out_data), 64'(0));
    chk("rst_ps_valid", 64'(ps_out_valid), 64'(0));
    @(posedge clk); #1;
    ap_rst = 1'b0;

    // Pack, back-to-back, output always ready
    pk_out_ready = 1'b1;
    pk_send(16'h1111);
    pk_send(16'h2222);
    chk("t1_not_early", 64'(pk_out_valid), 64'(0));
    pk_send(16'h3333);
    chk("t1_valid", 64'(pk_out_valid), 64'(1));
    chk("t1_data", 64'(pk_out_data), 64'h333322221111);
    repeat (2) @(posedge clk); #1;
    chk("t1_drained", 64'(pk_out_valid), 64'(0));

    // Pack under back-pressure: six beats offered, five fit
    pk_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) t2[i] = 16'($urandom);
    acc_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc_cnt < 6) begin pk_in_valid = 1'b1; pk_in_data = t2[acc_cnt]; end
      @(negedge clk);
      if (pk_in_valid && pk_in_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    chk("t2_accepted", 64'(acc_cnt), 64'(5));
    chk("t2_beat6_ready", 64'(pk_in_ready), 64'(0));
    chk("t2_word1_valid", 64'(pk_out_valid), 64'(1));
    chk("t2_word1_data", 64'(pk_out_data), 64'({t2[2], t2[1], t2[0]}));
    pk_out_ready = 1'b1;
    pk_send(t2[5]);
    chk("t2_word2_valid", 64'(pk_out_valid), 64'(1));
    chk("t2_word2_data", 64'(pk_out_data), 64'({t2[5], t2[4], t2[3]}));
    @(posedge clk); #1;
    chk("t2_drained", 64'(pk_out_valid), 64'(0));

    // Pack, reset after two of three beats drops the partial word
    pk_send(16'($urandom));
    pk_send(16'($urandom));
    ap_rst = 1'b1; pk_in_valid = 1'b1; pk_in_data = 16'h0A0A;
    repeat (2) begin
      @(negedge clk);
      chk("t5_rst_valid", 64'(pk_out_valid), 64'(0));
      chk("t5_rst_ready", 64'(pk_in_ready), 64'(0));
      @(posedge clk); #1;
    end
    ap_rst = 1'b0; pk_in_valid = 1'b0;
    base = pk_out_cnt;
    pk_send(16'h0A0A);
    pk_send(16'h0B0B);
    pk_send(16'h0C0C);
    chk("t5_data", 64'(pk_out_data), 64'h0C0C0B0B0A0A);
    repeat (3) @(posedge clk); #1;
    chk("t5_sole_output", 64'(pk_out_cnt - base), 64'(1));

    // Split, two words with no bubble between them
    sp_out_ready = 1'b1;
    exp3 = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
    fork
      begin
        sp_send(48'hCCCCBBBBAAAA);
        sp_send(48'hFFFFEEEEDDDD);
      end
      begin
        w = 0;
        while (!sp_out_valid && w < 20) begin @(negedge clk); w++; end
        for (int i = 0; i < 6; i++) begin
          chk("t3_valid", 64'(sp_out_valid), 64'(1));
          chk("t3_slice", 64'(sp_out_data), 64'(exp3[i]));
          @(negedge clk);
        end
        chk("t3_done", 64'(sp_out_valid), 64'(0));
      end
    join
    @(posedge clk); #1;

    // Split, random traffic on both sides
    base = sp_out_cnt;
    fork
      begin
        for (int n = 0; n < 3000; n++) begin
          if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
          r48 = {16'($urandom), 32'($urandom)};
          sp_send(r48);
        end
        sp_done = 1'b1;
      end
      begin
        while (!sp_done) begin
          sp_out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    sp_out_ready = 1'b1;
    w = 0;
    while (sp_exp.size() != 0 && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    chk("t4_drained", 64'(sp_exp.size()), 64'(0));
    chk("t4_count", 64'(sp_out_cnt - base), 64'(9000));
    chk("t4_idle", 64'(sp_out_valid), 64'(0));

    // Pass mode: latency 1, then alternating ready
    ps_out_ready = 1'b1;
    base = ps_out_cnt;
    ps_send(16'hBEEF);
    chk("t6_latency_valid", 64'(ps_out_valid), 64'(1));
    chk("t6_latency_data", 64'(ps_out_data), 64'hBEEF);
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          ps_send(16'($urandom));
        end
        ps_done = 1'b1;
      end
      begin
        while (!ps_done) begin
          ps_out_ready = !ps_out_ready;
          @(posedge clk); #1;
        end
      end
    join
    ps_out_ready = 1'b1;
    w = 0;
    while (ps_exp.size() != 0 && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    chk("t6_drained", 64'(ps_exp.size()), 64'(0));
    chk("t6_count", 64'(ps_out_cnt - base), 64'(201));

    ap_rst = 1'b1; ps_in_valid = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", 64'(ps_in_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_valid", 64'(ps_out_valid), 64'(0));
    @(posedge clk); #1;
    ap_rst = 1'b0; ps_in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
